// File: rtl/dcsk_pkg.sv
// dcsk_pkg: shared types and helpers for the DCSK transmitter.
//   dcsk_state_e : transmitter FSM states
//   sf_code_t    : 2-bit spreading-factor code
//   sf_len()     : chips per segment for a given code
package dcsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REF  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } dcsk_state_e;

    typedef logic [1:0] sf_code_t;

    function automatic int unsigned sf_len(input int unsigned sf_min, input sf_code_t code);
        return sf_min << code;
    endfunction

endpackage

// File: rtl/chaos_gen.sv
// chaos_gen: Galois LFSR used as the chaotic reference source.
//   i_clk, i_arst_n : clock, async active-low reset (state -> SEED_DEFAULT)
//   i_load          : load i_seed (a zero seed is replaced by 1)
//   i_advance       : step the generator once
//   i_seed          : seed value
//   o_chip          : current chip, state bit 0
module chaos_gen #(
    parameter int unsigned          CHAOS_W      = 8,
    parameter logic [CHAOS_W-1:0]   TAPS         = CHAOS_W'(8'hB8),
    parameter logic [CHAOS_W-1:0]   SEED_DEFAULT = CHAOS_W'(1)
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_load,
    input  logic               i_advance,
    input  logic [CHAOS_W-1:0] i_seed,
    output logic               o_chip
);

    logic [CHAOS_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (i_load) begin
            // the all-zero state is a fixed point of the LFSR
            state_d = (i_seed == '0) ? CHAOS_W'(1) : i_seed;
        end else if (i_advance) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= SEED_DEFAULT;
        else           state_q <= state_d;
    end

    assign o_chip = state_q[0];

endmodule

// File: rtl/dcsk_tx_core.sv
// dcsk_tx_core: differential chaos-shift-keying transmitter.
// Each message bit is sent as a reference segment of SF chaos chips followed
// by a data segment that repeats (bit 1) or inverts (bit 0) that reference.
//   i_clk, i_arst_n : clock, async active-low reset
//   i_msg, i_send   : frame payload and request (accepted only when o_ready)
//   i_seed, i_load_seed : generator seed load (IDLE only)
//   i_sf            : spreading-factor code, SF = SF_MIN << i_sf
//   o_tx, o_tx_valid: chip output (1 = +1, 0 = -1) and qualifier
//   o_ready, o_done : idle indicator, one-cycle end-of-frame pulse
//
// state   | meaning
// IDLE    | waiting for i_send, seed loads allowed
// REF     | emitting chaos reference chips, filling ref buffer
// DATA    | emitting buffered chips modulated by current bit
// DONE    | single end-of-frame cycle
module dcsk_tx_core
    import dcsk_pkg::*;
#(
    parameter int unsigned          MSG_W        = 32,
    parameter int unsigned          CHAOS_W      = 8,
    parameter logic [CHAOS_W-1:0]   TAPS         = CHAOS_W'(8'hB8),
    parameter logic [CHAOS_W-1:0]   SEED_DEFAULT = CHAOS_W'(1),
    parameter int unsigned          SF_MIN       = 8,
    parameter bit                   MSB_FIRST    = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic [MSG_W-1:0]   i_msg,
    input  logic               i_send,
    input  logic [CHAOS_W-1:0] i_seed,
    input  logic               i_load_seed,
    input  logic [1:0]         i_sf,
    output logic               o_tx,
    output logic               o_tx_valid,
    output logic               o_ready,
    output logic               o_done
);

    localparam int unsigned SF_MAX = 8 * SF_MIN;
    localparam int unsigned CW     = $clog2(SF_MAX);
    localparam int unsigned BW     = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    dcsk_state_e      state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [CW-1:0]    sf_last_q, sf_last_d;
    logic [CW-1:0]    chip_q, chip_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             ref_buf_q [SF_MAX];

    logic             gen_load, gen_adv, gen_chip;
    logic [BW-1:0]    bit_sel;
    logic             msg_bit;
    logic             seg_end;

    chaos_gen #(
        .CHAOS_W      (CHAOS_W),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_chaos_gen (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_load    (gen_load),
        .i_advance (gen_adv),
        .i_seed    (i_seed),
        .o_chip    (gen_chip)
    );

    // bit_q always counts up; the order flip happens only at the select
    assign bit_sel = MSB_FIRST ? (BW'(MSG_W - 1) - bit_q) : bit_q;
    assign msg_bit = msg_q[bit_sel];
    assign seg_end = (chip_q == sf_last_q);

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        sf_last_d  = sf_last_q;
        chip_d     = chip_q;
        bit_d      = bit_q;
        gen_load   = 1'b0;
        gen_adv    = 1'b0;
        o_tx       = 1'b0;
        o_tx_valid = 1'b0;
        o_ready    = 1'b0;
        o_done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_ready  = 1'b1;
                gen_load = i_load_seed;
                if (i_send) begin
                    msg_d     = i_msg;
                    sf_last_d = CW'(sf_len(SF_MIN, i_sf) - 1);
                    chip_d    = '0;
                    bit_d     = '0;
                    state_d   = ST_REF;
                end
            end
            ST_REF: begin
                o_tx       = gen_chip;
                o_tx_valid = 1'b1;
                gen_adv    = 1'b1;
                if (seg_end) begin
                    chip_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    chip_d = chip_q + 1'b1;
                end
            end
            ST_DATA: begin
                o_tx       = ref_buf_q[chip_q] ~^ msg_bit;
                o_tx_valid = 1'b1;
                if (seg_end) begin
                    chip_d = '0;
                    if (bit_q == BW'(MSG_W - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_REF;
                    end
                end else begin
                    chip_d = chip_q + 1'b1;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_IDLE;
            msg_q     <= '0;
            sf_last_q <= '0;
            chip_q    <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            sf_last_q <= sf_last_d;
            chip_q    <= chip_d;
            bit_q     <= bit_d;
        end
    end

    // reference buffer needs no reset: every entry is written before it is read
    always_ff @(posedge i_clk) begin
        if (state_q == ST_REF) ref_buf_q[chip_q] <= gen_chip;
    end

endmodule

// File: tb/tb_dcsk_tx_core.sv
module tb_dcsk_tx_core;

    logic       clk;
    logic       arst_n;
    logic [3:0] msg_a, msg_b;
    logic       send_a, send_b;
    logic [7:0] seed;
    logic       load_seed;
    logic [1:0] sf;
    logic       tx_a, valid_a, ready_a, done_a;
    logic       tx_b, valid_b, ready_b, done_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_a, m_b;   // generator models for the two instances

    dcsk_tx_core #(
        .MSG_W(4), .CHAOS_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01),
        .SF_MIN(4), .MSB_FIRST(1'b1)
    ) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_msg(msg_a), .i_send(send_a),
        .i_seed(seed), .i_load_seed(load_seed), .i_sf(sf),
        .o_tx(tx_a), .o_tx_valid(valid_a), .o_ready(ready_a), .o_done(done_a)
    );

    dcsk_tx_core #(
        .MSG_W(4), .CHAOS_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01),
        .SF_MIN(4), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .i_clk(clk), .i_arst_n(arst_n), .i_msg(msg_b), .i_send(send_b),
        .i_seed(seed), .i_load_seed(load_seed), .i_sf(sf),
        .o_tx(tx_b), .o_tx_valid(valid_b), .o_ready(ready_b), .o_done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gstep(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s);
        seed      = s;
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
        m_a = (s == 8'h00) ? 8'h01 : s;
        m_b = m_a;
    endtask

    // Runs one frame on instance A (lsb=0) or B (lsb=1) and checks every chip
    // against the Galois model; poke_at >= 0 injects send/load(0)/msg/sf
    // changes at that chip index, which must have no effect.
    task automatic run_frame(input logic lsb, input logic [3:0] msg, input logic [1:0] sfc,
                             input logic ld, input logic [7:0] ld_seed, input int poke_at,
                             input string name, output logic [3:0] first4);
        int   seg_len, idx, bad_tx, bad_v, bad_rdy, bad_dn, first_bad;
        logic refb [32];
        logic mdl_chip, exp_tx, b, o_t, o_v, o_r, o_d;
        logic [7:0] mdl;
        seg_len = 4 << sfc;
        idx = 0; bad_tx = 0; bad_v = 0; bad_rdy = 0; bad_dn = 0; first_bad = -1;
        first4 = 4'b0000;
        sf = sfc;
        if (lsb) begin send_b = 1'b1; msg_b = msg; end
        else     begin send_a = 1'b1; msg_a = msg; end
        if (ld) begin
            seed = ld_seed; load_seed = 1'b1;
            m_a = (ld_seed == 8'h00) ? 8'h01 : ld_seed;
            m_b = m_a;
        end
        tick();
        send_a = 1'b0; send_b = 1'b0; load_seed = 1'b0;
        mdl = lsb ? m_b : m_a;
        for (int s = 0; s < 4; s++) begin
            b = lsb ? msg[s] : msg[3-s];
            for (int ph = 0; ph < 2; ph++) begin
                for (int k = 0; k < seg_len; k++) begin
                    o_t = lsb ? tx_b : tx_a;
                    o_v = lsb ? valid_b : valid_a;
                    o_r = lsb ? ready_b : ready_a;
                    o_d = lsb ? done_b : done_a;
                    if (ph == 0) begin
                        mdl_chip = mdl[0];
                        refb[k]  = mdl_chip;
                        exp_tx   = mdl_chip;
                        mdl      = gstep(mdl);
                        if (s == 0 && k < 4) first4[k] = o_t;
                    end else begin
                        exp_tx = refb[k] ~^ b;
                    end
                    if (o_t !== exp_tx) begin
                        bad_tx++;
                        if (first_bad < 0) first_bad = idx;
                    end
                    if (o_v !== 1'b1) bad_v++;
                    if (o_r !== 1'b0) bad_rdy++;
                    if (o_d !== 1'b0) bad_dn++;
                    if (idx == poke_at) begin
                        send_a = 1'b1; send_b = 1'b0; load_seed = 1'b1; seed = 8'h00;
                        msg_a = ~msg; sf = ~sfc;
                        m_b = 8'h01;   // the idle instance does take this load
                    end else begin
                        send_a = 1'b0; load_seed = 1'b0; msg_a = msg; sf = sfc;
                    end
                    tick();
                    idx++;
                end
            end
        end
        send_a = 1'b0; load_seed = 1'b0;
        if (lsb) m_b = mdl; else m_a = mdl;

        checks++;
        if (bad_tx !== 0) begin
            errors++;
            $display("FAIL %s chips: %0d wrong chips (first at %0d), required 0", name, bad_tx, first_bad);
        end
        checks++;
        if (bad_v !== 0 || bad_dn !== 0) begin
            errors++;
            $display("FAIL %s valid/done in frame: %0d/%0d bad cycles, required 0/0", name, bad_v, bad_dn);
        end
        checks++;
        if (bad_rdy !== 0) begin
            errors++;
            $display("FAIL %s ready in frame: high on %0d cycles, required 0", name, bad_rdy);
        end
        o_v = lsb ? valid_b : valid_a;
        o_t = lsb ? tx_b : tx_a;
        o_d = lsb ? done_b : done_a;
        checks++;
        if ({o_d, o_v, o_t} !== 3'b100) begin
            errors++;
            $display("FAIL %s done cycle %0d: done/valid/tx=%b%b%b, required 100", name, idx + 1, o_d, o_v, o_t);
        end
        tick();
        o_r = lsb ? ready_b : ready_a;
        o_d = lsb ? done_b : done_a;
        checks++;
        if ({o_r, o_d} !== 2'b10) begin
            errors++;
            $display("FAIL %s after done: ready/done=%b%b, required 10", name, o_r, o_d);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({tx_a, valid_a, ready_a, done_a} !== 4'b0010) begin
            errors++;
            $display("FAIL %s: tx/valid/ready/done=%b%b%b%b, required 0010", name, tx_a, valid_a, ready_a, done_a);
        end
        checks++;
        if ({tx_b, valid_b, ready_b, done_b} !== 4'b0010) begin
            errors++;
            $display("FAIL %s lsb: tx/valid/ready/done=%b%b%b%b, required 0010", name, tx_b, valid_b, ready_b, done_b);
        end
    endtask

    task automatic check_first4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s first REF chips: got %b, required %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [3:0] f4;
        arst_n = 1'b0; send_a = 1'b0; send_b = 1'b0; msg_a = '0; msg_b = '0;
        seed = '0; load_seed = 1'b0; sf = '0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        arst_n = 1'b1;
        m_a = 8'h01; m_b = 8'h01;
        tick();
        // seed 01 -> chips 1,0,0,0
        run_frame(1'b0, 4'b0110, 2'd0, 1'b0, 8'h00, -1, "reset_default", f4);
        check_first4("reset_default", f4, 4'b0001);
    endtask

    task automatic test_basic();
        logic [3:0] f4;
        do_load(8'hA5);
        // A5 -> EA -> 75 -> 82 : chips 1,0,1,0
        run_frame(1'b0, 4'b1010, 2'd0, 1'b0, 8'h00, -1, "basic_a5", f4);
        check_first4("basic_a5", f4, 4'b0101);
    endtask

    task automatic test_sf3();
        logic [3:0] f4;
        run_frame(1'b0, 4'b0110, 2'd3, 1'b0, 8'h00, -1, "sf3", f4);
    endtask

    task automatic test_busy_ignored();
        logic [3:0] f4;
        run_frame(1'b0, 4'b1100, 2'd1, 1'b0, 8'h00, 5, "busy_poke", f4);
        check_idle_outputs("after_busy");
        do_load(8'h00);
        run_frame(1'b0, 4'b0011, 2'd0, 1'b0, 8'h00, -1, "zero_seed", f4);
        check_first4("zero_seed", f4, 4'b0001);
    endtask

    task automatic test_load_and_send();
        logic [3:0] f4;
        // 3C -> 1E -> 0F -> BF : chips 0,0,1,1
        run_frame(1'b0, 4'b1001, 2'd0, 1'b1, 8'h3C, -1, "load_send_3c", f4);
        check_first4("load_send_3c", f4, 4'b1100);
    endtask

    task automatic test_back_to_back();
        logic [3:0] f4;
        run_frame(1'b0, 4'b1111, 2'd0, 1'b0, 8'h00, -1, "b2b_1", f4);
        run_frame(1'b0, 4'b0000, 2'd2, 1'b0, 8'h00, -1, "b2b_2", f4);
    endtask

    task automatic test_reset_mid();
        logic [3:0] f4;
        sf = 2'd0; msg_a = 4'b1010; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        arst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        tick();
        arst_n = 1'b1;
        m_a = 8'h01; m_b = 8'h01;
        run_frame(1'b0, 4'b1010, 2'd0, 1'b0, 8'h00, -1, "after_reset_mid", f4);
        check_first4("after_reset_mid", f4, 4'b0001);
    endtask

    task automatic test_lsb_first();
        logic [3:0] f4;
        do_load(8'hA5);
        run_frame(1'b1, 4'b0001, 2'd0, 1'b0, 8'h00, -1, "lsb_first", f4);
        check_first4("lsb_first", f4, 4'b0101);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sf3();
        test_busy_ignored();
        test_load_and_send();
        test_back_to_back();
        test_reset_mid();
        test_lsb_first();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
